dct2d_ctrl: RTL and testbench
=============================

Name: dct2d_ctrl

Overview:
- Sequences one shared, purely combinational 8-point 1-D DCT datapath (64-bit row in, 72-bit 9-bit-lane coefficients out) to compute an 8x8 2-D DCT.
- Row pass: accepts 8 pixel rows, drives each through the datapath and stores the results in an internal 8x8x9-bit transpose buffer.
- Column pass: drives each buffer column back through the same datapath and streams the 8 column results out under valid/ready.
- Sits between the block-fetch stage and the quantiser.

Parameters:
CNT_W, 16, width of the completed-block counter blk_cnt (wraps modulo 2^CNT_W).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_row holds a valid pixel row.
in_ready  output  1  controller accepts a row this cycle.
in_row  input  64  8 signed 8-bit pixels; element 0 in [63:56], element 7 in [7:0].
out_valid  output  1  out_col holds a valid column result.
out_ready  input  1  downstream accepts out_col this cycle.
out_col  output  72  8 signed 9-bit coefficients; lane 0 in [71:63], lane 7 in [8:0].
out_idx  output  3  column index 0..7 of current out_col.
out_last  output  1  high with out_valid when out_idx==7.
dct_in  output  64  drive to shared 1-D DCT input, same packing as in_row.
dct_out  input  72  shared 1-D DCT result, same packing as out_col.
busy  output  1  high whenever state != LOAD or row_cnt != 0.
blk_done  output  1  one-cycle pulse on the cycle the last column handshakes.
blk_cnt  output  CNT_W  number of completed blocks.

Behaviour:
- Reset (async, rst_n=0):
  - Registers: state=LOAD, row_cnt=0, col_cnt=0, blk_cnt=0, blk_done=0.
  - Outputs: in_ready=1, out_valid=0, busy=0.
  - Buffer contents are don't-care.
- States: LOAD, COL.
- LOAD:
  - in_ready=1, out_valid=0, dct_in=in_row.
  - On in_valid&&in_ready: buf[row_cnt] <= dct_out, then row_cnt++.
  - If row_cnt==7 at that handshake: row_cnt <= 0, col_cnt <= 0, state <= COL.
  - in_valid low: hold; no write.
- COL:
  - in_ready=0; in_valid is ignored and no row is consumed.
  - dct_in byte r (r=0..7, byte 0 at [63:56]) = buf[r] lane col_cnt, bits [8:1]. This is a 9-to-8-bit arithmetic shift right by 1 (scale 1/2, sign preserved, truncating).
  - out_valid=1, out_col=dct_out, out_idx=col_cnt, out_last=(col_cnt==7).
  - On out_valid&&out_ready: col_cnt++. If col_cnt==7: state <= LOAD, blk_done <= 1 for one cycle, blk_cnt++.
  - out_ready low: col_cnt and buffer hold, so out_col, out_idx and out_last stay stable until accepted.
- Latency:
  - Handshake of row 8 at cycle T gives out_valid=1 at T+1.
  - With out_ready=1 continuously, the column with idx 7 is accepted at T+8 and in_ready=1 at T+9.
  - Block period is therefore 16 cycles minimum.
- No overlap: a new block's rows are not accepted until its predecessor's last column handshakes. The last column handshake and the first new row handshake can never fall in the same cycle.
- Lane 7 from the datapath is passed through unmodified. The controller does not special-case it.
- Reset mid-block: the partial block is discarded, and no blk_done or blk_cnt increment occurs for it.
- blk_cnt wraps from 2^CNT_W-1 to 0.
- All arithmetic is in the external datapath. The controller only does muxing, bit selection and counting.

Test Plan:
- Reset then 8 rows of all-zero pixels, out_ready=1 -> out_col=0 for idx 0..7; out_last only at idx 7; blk_done pulses once; blk_cnt=1.
- 8 rows of all pixels=64, out_ready=1 -> the row pass stores lane0=45 and other lanes 0. Column idx 0 lane 0 = 15 (9'h00F), all other lanes and columns 0. out_valid starts one cycle after the 8th row handshake.
- 8 rows of all pixels=-64 -> the row pass stores lane0=-45 and the column input is -23. Column idx 0 lane 0 = -16 (9'h1F0), everything else 0.
- Constant-64 block with out_ready toggling 1,0,0,1,... and in_valid held high throughout COL -> each column is held stable while stalled. in_ready=0 and no row is consumed during COL. Output sequence is identical to the unstalled run.
- Row input with gaps (in_valid low on alternate cycles) -> row_cnt advances only on handshakes; results are the same as the gapless run.
- Assert rst_n=0 after 5 rows, then feed a full constant-64 block -> output matches the constant-64 result; blk_cnt=1, not 2.

Source files
------------

// File: rtl/dct2d_ctrl_if.sv
// Row-in / column-out stream bundle between the DCT controller and its neighbours.
// master = fetch/quantiser side, slave = dct2d_ctrl.
interface dct2d_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_row;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_col;
  logic [2:0]  out_idx;
  logic        out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_idx, out_last
  );
endinterface

// File: rtl/dct2d_ctrl.sv
// 8x8 2-D DCT sequencer over one shared 1-D datapath; first column 1 cycle after row 8, 16-cycle block minimum.
// Backpressure: in_ready drops for the whole column pass; out_ready low freezes col_cnt so out_col holds.
module dct2d_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dct2d_ctrl_if.slave      io,
  output logic [63:0]      dct_in,
  input  logic [71:0]      dct_out,
  output logic             busy,
  output logic             blk_done,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic {
    LOAD = 1'b0,
    COL  = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  row_cnt;
  logic [2:0]  col_cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        row_hs;
  logic        col_hs;
  logic [63:0] col_gather;
  logic [71:0] row_buf [8];

  assign row_hs = in_ready_q && io.in_valid;
  assign col_hs = out_valid_q && io.out_ready;

  // Column feed: bits [8:1] of each stored lane halve the row coefficient into an 8-bit pixel slot.
  always_comb begin
    col_gather = '0;
    for (int r = 0; r < 8; r++) begin
      col_gather[63 - 8*r -: 8] = row_buf[r][71 - 9*int'(col_cnt) -: 8];
    end
  end

  assign dct_in = (state == COL) ? col_gather : io.in_row;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_col   = dct_out;
  assign io.out_idx   = col_cnt;
  assign io.out_last  = out_valid_q && (col_cnt == 3'd7);
  assign busy         = (state != LOAD) || (row_cnt != 3'd0);

  // Transpose buffer carries no reset: it is always fully rewritten before a column pass reads it.
  always_ff @(posedge clk) begin
    if (row_hs) begin
      row_buf[row_cnt] <= dct_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      row_cnt     <= 3'd0;
      col_cnt     <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      blk_done    <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        LOAD: begin
          if (row_hs) begin
            if (row_cnt == 3'd7) begin
              row_cnt     <= 3'd0;
              col_cnt     <= 3'd0;
              state       <= COL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        COL: begin
          if (col_hs) begin
            if (col_cnt == 3'd7) begin
              col_cnt     <= 3'd0;
              state       <= LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              blk_done    <= 1'b1;
              blk_cnt     <= blk_cnt + CNT_W'(1);
            end else begin
              col_cnt <= col_cnt + 3'd1;
            end
          end
        end
        default: begin
          state       <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct2d_ctrl.sv
// Scoreboard bench for dct2d_ctrl: a behavioural 1-D DCT stands in for the shared datapath,
// and the 2-D reference is built from integer arrays at block level.
module tb_dct2d_ctrl;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic [63:0]      dct_in;
  logic [71:0]      dct_out;
  logic             busy;
  logic             blk_done;
  logic [CNT_W-1:0] blk_cnt;

  dct2d_ctrl_if bus ();

  dct2d_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .dct_in   (dct_in),
    .dct_out  (dct_out),
    .busy     (busy),
    .blk_done (blk_done),
    .blk_cnt  (blk_cnt)
  );

  typedef struct {
    logic [71:0] col;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          or_mode = 0;
  int          or_cnt = 0;
  int          exp_blk = 0;
  int          rows_seen = 0;
  bit          lat_pend = 0;
  bit          done_exp = 0;
  logic [63:0] blk_rows [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Orthogonal DCT-II scaled by 1/8, coefficients in Q12, truncated toward zero.
  function automatic int cos_tab(input int m);
    case (m)
      0: return 4096;
      1: return 4017;
      2: return 3784;
      3: return 3406;
      4: return 2896;
      5: return 2276;
      6: return 1567;
      7: return 799;
      default: return 0;
    endcase
  endfunction

  function automatic int coef(input int k, input int n);
    int m;
    if (k == 0) return 2896;
    m = ((2*n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m <= 8) return cos_tab(m);
    return -cos_tab(16 - m);
  endfunction

  function automatic int dot8(input int v[8], input int k);
    longint acc;
    acc = 0;
    for (int n = 0; n < 8; n++) acc += longint'(v[n]) * longint'(coef(k, n));
    return int'(acc / 32768);
  endfunction

  function automatic logic [71:0] dct1d(input logic [63:0] x);
    int          v[8];
    int          c;
    logic [71:0] y;
    y = '0;
    for (int n = 0; n < 8; n++) v[n] = int'($signed(x[63 - 8*n -: 8]));
    for (int k = 0; k < 8; k++) begin
      c = dot8(v, k);
      y[71 - 9*k -: 9] = c[8:0];
    end
    return y;
  endfunction

  always_comb dct_out = dct1d(dct_in);

  // Reference: rows -> coefficient matrix, halve (floor), then transform each column.
  task automatic push_expected();
    int   rc[8][8];
    int   v[8];
    int   ci[8];
    int   o;
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 8; n++) v[n] = int'($signed(blk_rows[r][63 - 8*n -: 8]));
      for (int k = 0; k < 8; k++) rc[r][k] = dot8(v, k);
    end
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) ci[r] = rc[r][c] >>> 1;
      e.col = '0;
      for (int k = 0; k < 8; k++) begin
        o = dot8(ci, k);
        e.col[71 - 9*k -: 9] = o[8:0];
      end
      e.idx  = 3'(c);
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    or_cnt++;
    case (or_mode)
      1:       bus.out_ready = ((or_cnt % 3) == 0);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_blk   = 0;
      rows_seen = 0;
      lat_pend  = 0;
      done_exp  = 0;
    end else begin
      if (lat_pend) check("latency_out_valid", 72'(bus.out_valid), 72'(1));
      check("blk_done", 72'(blk_done), 72'(done_exp));
      if (done_exp) check("in_ready_after_last", 72'(bus.in_ready), 72'(1));
      check("blk_cnt", 72'(blk_cnt), 72'(exp_blk % (1 << CNT_W)));
      if (bus.out_valid) check("in_ready_during_col", 72'(bus.in_ready), 72'(0));
      if (bus.out_valid || rows_seen != 0) check("busy", 72'(busy), 72'(1));
      lat_pend = 0;
      done_exp = 0;
      if (bus.in_valid && bus.in_ready) begin
        rows_seen++;
        if (rows_seen == 8) begin
          rows_seen = 0;
          lat_pend  = 1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output idx=%0d col=%h required=none", bus.out_idx, bus.out_col);
        end else begin
          mon_e = sb.pop_front();
          check("out_col", bus.out_col, mon_e.col);
          check("out_idx", 72'(bus.out_idx), 72'(mon_e.idx));
          check("out_last", 72'(bus.out_last), 72'(mon_e.last));
          if (mon_e.last) begin
            done_exp = 1;
            exp_blk++;
          end
        end
      end
    end
  end

  task automatic send_row(input logic [63:0] r);
    bit hs;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_row   = r;
    forever begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL row_accept_timeout actual=no_handshake required=handshake");
        break;
      end
    end
  endtask

  task automatic send_block(input int nrows, input int gap_mode);
    if (nrows == 8) push_expected();
    for (int r = 0; r < nrows; r++) begin
      send_row(blk_rows[r]);
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic fill_const(input logic [7:0] p);
    for (int r = 0; r < 8; r++) blk_rows[r] = {8{p}};
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) blk_rows[r] = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_in_ready", 72'(bus.in_ready), 72'(1));
    check("rst_out_valid", 72'(bus.out_valid), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_blk_done", 72'(blk_done), 72'(0));
    check("rst_blk_cnt", 72'(blk_cnt), 72'(0));
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b1;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    fill_const(8'h00); send_block(8, 0); wait_drain();
    fill_const(8'h40); send_block(8, 0); wait_drain();
    fill_const(8'hC0); send_block(8, 0); wait_drain();

    // Stalled outputs, then the next block waits with in_valid high through the column pass.
    or_mode = 1;
    fill_const(8'h40); send_block(8, 0);
    fill_const(8'h40); send_block(8, 1);
    wait_drain();
    or_mode = 0;

    fill_const(8'h80); send_block(8, 0);
    fill_const(8'h7F); send_block(8, 2);
    wait_drain();

    or_mode = 2;
    for (int b = 0; b < 4; b++) begin
      fill_rand();
      send_block(8, 2);
    end
    wait_drain();
    or_mode = 0;

    // Abort a partial block with reset; only the following block may count.
    fill_rand();
    send_block(5, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_const(8'h40); send_block(8, 0); wait_drain();
    check("blk_cnt_after_reset", 72'(blk_cnt), 72'(1));

    // Enough back-to-back blocks to wrap the narrow counter.
    or_mode = 2;
    for (int b = 0; b < 8; b++) begin
      fill_rand();
      send_block(8, 0);
    end
    wait_drain();
    check("blk_cnt_wrapped", 72'(blk_cnt), 72'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
